mem_access_ctrl: RTL and testbench

- MEM-stage data-memory access controller.
- Takes load/store requests from the EX/MEM pipeline register and drives an SRAM-like request/handshake data bus.
- Stalls the pipeline until the access completes, then presents byte-lane select and held read data to the MEM/WB register for write-back alignment and sign extension.
- Also reports MIPS address-error exceptions.

---
 rtl/mem_access_ctrl_pkg.sv | 40 ++++
 rtl/mem_byte_lane.sv | 32 +++
 rtl/mem_access_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory access controller:
// access sizes, FSM states, bus widths and address-error exception codes.
package mem_access_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // The reserved size 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: is_misaligned = 1'b0;
      MEM_SIZE_HALF: is_misaligned = lo[0];
      default:       is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [1:0] aligned_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_SIZE_BYTE: aligned_lo = lo;
      MEM_SIZE_HALF: aligned_lo = {lo[1], 1'b0};
      default:       aligned_lo = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane helper: byte mask and lane-replicated store data
// from access size, low address bits and right-justified write data.
module mem_byte_lane
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  output logic [3:0]  mask,
  output logic [31:0] wdata
);

  always_comb begin
    mask  = 4'b1111;
    wdata = wd;
    case (size)
      MEM_SIZE_BYTE: begin
        mask  = 4'b0001 << addr_lo;
        wdata = {4{wd[7:0]}};
      end
      MEM_SIZE_HALF: begin
        mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        wdata = wd;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller driving an SRAM-like req/addr_ok/data_ok bus.
// Define MEM_ADDR_CHECK_EN to raise AdEL/AdES on misaligned accesses instead of aligning them.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_next_stage,
  input  logic                  valid_in,
  input  logic                  mem_read_flag_in,
  input  logic                  mem_write_flag_in,
  input  logic [1:0]            mem_size_in,
  input  logic [ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [DATA_WIDTH-1:0] mem_write_data_in,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_wdata,
  output logic [3:0]            data_wstrb,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_WIDTH-1:0] data_rdata,
  output logic [3:0]            mem_sel_out,
  output logic [DATA_WIDTH-1:0] ram_read_data_out,
  output logic                  stall_request,
  output logic                  addr_error_load,
  output logic                  addr_error_store,
  output logic [ADDR_WIDTH-1:0] bad_vaddr_out
);

  state_t state_reg, state_next;

  logic                  has_op, misaligned, access;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [3:0]            lane_mask, lane_wstrb;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic                  latch, capture, use_latched;

  logic [ADDR_WIDTH-1:0] req_addr_reg;
  logic                  req_wr_reg, req_rd_reg;
  logic [1:0]            req_size_reg;
  logic [DATA_WIDTH-1:0] req_wdata_reg;
  logic [3:0]            req_wstrb_reg, req_mask_reg;
  logic [3:0]            mem_sel_reg;
  logic [DATA_WIDTH-1:0] ram_read_data_reg;

  assign has_op = valid_in & (mem_read_flag_in | mem_write_flag_in);

`ifdef MEM_ADDR_CHECK_EN
  logic addr_err;
  assign misaligned       = is_misaligned(mem_size_in, mem_addr_in[1:0]);
  assign issue_addr       = mem_addr_in;
  assign addr_err         = valid_in & ~flush & misaligned;
  assign addr_error_load  = addr_err & mem_read_flag_in;
  assign addr_error_store = addr_err & mem_write_flag_in;
  assign bad_vaddr_out    = addr_err ? mem_addr_in : '0;
`else
  // Without checking, misaligned addresses are silently rounded down to the access size.
  assign misaligned       = 1'b0;
  assign issue_addr       = {mem_addr_in[ADDR_WIDTH-1:2], aligned_lo(mem_size_in, mem_addr_in[1:0])};
  assign addr_error_load  = 1'b0;
  assign addr_error_store = 1'b0;
  assign bad_vaddr_out    = '0;
`endif

  assign access = has_op & ~flush & ~misaligned;

  mem_byte_lane u_lane (
    .size    (mem_size_in),
    .addr_lo (issue_addr[1:0]),
    .wd      (mem_write_data_in),
    .mask    (lane_mask),
    .wdata   (lane_wdata)
  );

  assign lane_wstrb = mem_write_flag_in ? lane_mask : 4'b0000;

  always_comb begin
    state_next    = state_reg;
    data_req      = 1'b0;
    stall_request = 1'b0;
    latch         = 1'b0;
    capture       = 1'b0;
    use_latched   = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        use_latched   = 1'b0;
        data_req      = access;
        stall_request = access;
        latch         = access;
        if (access) state_next = data_addr_ok ? ST_WAIT : ST_REQ;
      end
      ST_REQ: begin
        // A flush withdraws the request before the bus can accept it.
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          data_req      = 1'b1;
          stall_request = 1'b1;
          if (data_addr_ok) state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_request = 1'b1;
        if (data_data_ok) begin
          capture       = 1'b1;
          stall_request = 1'b0;
          state_next    = stall_next_stage ? ST_DONE : ST_IDLE;
        end else if (flush) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!stall_next_stage) state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_request = has_op;
        if (data_data_ok) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign data_wr    = use_latched ? req_wr_reg    : mem_write_flag_in;
  assign data_size  = use_latched ? req_size_reg  : mem_size_in;
  assign data_addr  = use_latched ? req_addr_reg  : issue_addr;
  assign data_wdata = use_latched ? req_wdata_reg : lane_wdata;
  assign data_wstrb = use_latched ? req_wstrb_reg : lane_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      req_addr_reg      <= '0;
      req_wr_reg        <= 1'b0;
      req_rd_reg        <= 1'b0;
      req_size_reg      <= '0;
      req_wdata_reg     <= '0;
      req_wstrb_reg     <= '0;
      req_mask_reg      <= '0;
      mem_sel_reg       <= '0;
      ram_read_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (latch) begin
        req_addr_reg  <= issue_addr;
        req_wr_reg    <= mem_write_flag_in;
        req_rd_reg    <= mem_read_flag_in;
        req_size_reg  <= mem_size_in;
        req_wdata_reg <= lane_wdata;
        req_wstrb_reg <= lane_wstrb;
        req_mask_reg  <= lane_mask;
      end
      if (capture) begin
        mem_sel_reg <= req_mask_reg;
        if (req_rd_reg) ram_read_data_reg <= data_rdata;
      end
    end
  end

  assign mem_sel_out       = mem_sel_reg;
  assign ram_read_data_out = ram_read_data_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: table of combinational issue vectors in IDLE,
// then hand-written multi-cycle sequences (latency, delayed addr_ok, flush/drain, DONE hold, reset).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, stall_next_stage, valid_in;
  logic        mem_read_flag_in, mem_write_flag_in;
  logic [1:0]  mem_size_in;
  logic [31:0] mem_addr_in, mem_write_data_in;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  mem_sel_out;
  logic [31:0] ram_read_data_out;
  logic        stall_request, addr_error_load, addr_error_store;
  logic [31:0] bad_vaddr_out;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_next_stage(stall_next_stage),
    .valid_in(valid_in), .mem_read_flag_in(mem_read_flag_in),
    .mem_write_flag_in(mem_write_flag_in), .mem_size_in(mem_size_in),
    .mem_addr_in(mem_addr_in), .mem_write_data_in(mem_write_data_in),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_sel_out(mem_sel_out), .ram_read_data_out(ram_read_data_out),
    .stall_request(stall_request), .addr_error_load(addr_error_load),
    .addr_error_store(addr_error_store), .bad_vaddr_out(bad_vaddr_out)
  );

  typedef struct {
    logic        valid, rd, wr, flush;
    logic [1:0]  size;
    logic [31:0] addr, wd;
    logic        e_req, e_wr, e_stall, e_adel, e_ades;
    logic [31:0] e_addr, e_wdata, e_bad;
    logic [3:0]  e_wstrb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic valid, logic rd, logic wr, logic fl, logic [1:0] size,
                              logic [31:0] addr, logic [31:0] wd, logic e_req, logic e_stall,
                              logic [31:0] e_addr, logic [31:0] e_wdata, logic [3:0] e_wstrb,
                              logic e_adel, logic e_ades, logic [31:0] e_bad);
    vec_t v;
    v.valid = valid; v.rd = rd; v.wr = wr; v.flush = fl; v.size = size;
    v.addr = addr; v.wd = wd; v.e_req = e_req; v.e_wr = wr; v.e_stall = e_stall;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
    v.e_adel = e_adel; v.e_ades = e_ades; v.e_bad = e_bad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    valid_in = 0; mem_read_flag_in = 0; mem_write_flag_in = 0; flush = 0;
    mem_size_in = 2'b10; mem_addr_in = 0; mem_write_data_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_lw(input logic [31:0] addr, input logic aok);
    valid_in = 1; mem_read_flag_in = 1; mem_write_flag_in = 0;
    mem_size_in = 2'b10; mem_addr_in = addr; data_addr_ok = aok;
  endtask

  initial begin
    idle_inputs();
    rst = 1; stall_next_stage = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    tick(); tick();
    rst = 0;
    #1;
    chk("reset_req", data_req, 0);
    chk("reset_stall", stall_request, 0);
    chk("reset_rdata", ram_read_data_out, 0);
    chk("reset_sel", mem_sel_out, 0);

    // valid rd wr flush size addr wd | req stall addr wdata wstrb adel ades bad
    vecs.push_back(mk(1,1,0,0,2'b10,32'h8000_1000,32'h0, 1,1,32'h8000_1000,32'h0,4'b0000,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b00,32'h8000_0003,32'h0000_00A5, 1,1,32'h8000_0003,32'hA5A5_A5A5,4'b1000,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b00,32'h0000_0001,32'h1234_5677, 1,1,32'h1,32'h7777_7777,4'b0010,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b01,32'h0000_0102,32'h0000_BEEF, 1,1,32'h102,32'hBEEF_BEEF,4'b1100,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b01,32'h0000_0100,32'h0000_1234, 1,1,32'h100,32'h1234_1234,4'b0011,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b10,32'h0000_0200,32'hCAFE_F00D, 1,1,32'h200,32'hCAFE_F00D,4'b1111,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b11,32'h0000_0204,32'h0BAD_CAFE, 1,1,32'h204,32'h0BAD_CAFE,4'b1111,0,0,0));
    vecs.push_back(mk(1,1,0,1,2'b10,32'h0000_0500,32'h0, 0,0,32'h500,32'h0,4'b0000,0,0,0));
    vecs.push_back(mk(0,1,0,0,2'b10,32'h0000_0600,32'h0, 0,0,32'h600,32'h0,4'b0000,0,0,0));
    vecs.push_back(mk(1,0,0,0,2'b10,32'h0000_0700,32'h0, 0,0,32'h700,32'h0,4'b0000,0,0,0));
    vecs.push_back(mk(1,1,0,0,2'b00,32'h0000_0003,32'h0, 1,1,32'h3,32'h0,4'b0000,0,0,0));
`ifdef MEM_ADDR_CHECK_EN
    vecs.push_back(mk(1,1,0,0,2'b10,32'h0000_1002,32'h0, 0,0,32'h1002,32'h0,4'b0000,1,0,32'h1002));
    vecs.push_back(mk(1,0,1,0,2'b01,32'h0000_0103,32'h0000_ABCD, 0,0,32'h103,32'hABCD_ABCD,4'b1100,0,1,32'h103));
`else
    vecs.push_back(mk(1,1,0,0,2'b10,32'h0000_1002,32'h0, 1,1,32'h1000,32'h0,4'b0000,0,0,0));
    vecs.push_back(mk(1,0,1,0,2'b01,32'h0000_0103,32'h0000_ABCD, 1,1,32'h102,32'hABCD_ABCD,4'b1100,0,0,0));
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      valid_in = vecs[i].valid; mem_read_flag_in = vecs[i].rd; mem_write_flag_in = vecs[i].wr;
      flush = vecs[i].flush; mem_size_in = vecs[i].size; mem_addr_in = vecs[i].addr;
      mem_write_data_in = vecs[i].wd;
      #1;
      chk($sformatf("v%0d_req", i), data_req, vecs[i].e_req);
      chk($sformatf("v%0d_stall", i), stall_request, vecs[i].e_stall);
      chk($sformatf("v%0d_addr", i), data_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_wr", i), data_wr, vecs[i].e_wr);
      chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_wstrb", i), data_wstrb, vecs[i].e_wstrb);
      chk($sformatf("v%0d_adel", i), addr_error_load, vecs[i].e_adel);
      chk($sformatf("v%0d_ades", i), addr_error_store, vecs[i].e_ades);
      chk($sformatf("v%0d_bad", i), bad_vaddr_out, vecs[i].e_bad);
      $display("vector %0d: addr=%h req=%b wstrb=%b", i, vecs[i].addr, data_req, data_wstrb);
      idle_inputs();
    end

    // A: LW, addr_ok in issue cycle, data_ok two cycles later
    @(negedge clk);
    start_lw(32'h8000_1000, 1);
    #1;
    chk("A_issue_req", data_req, 1);
    chk("A_issue_stall", stall_request, 1);
    tick();
    data_addr_ok = 0; #1;
    chk("A_wait_req", data_req, 0);
    chk("A_wait_stall", stall_request, 1);
    tick();
    data_data_ok = 1; data_rdata = 32'hDEAD_BEEF; #1;
    chk("A_ok_stall", stall_request, 0);
    tick();
    data_data_ok = 0; idle_inputs(); #1;
    chk("A_rdata", ram_read_data_out, 32'hDEAD_BEEF);
    chk("A_sel", mem_sel_out, 4'b1111);
    $display("seq A: LW rdata=%h sel=%b", ram_read_data_out, mem_sel_out);

    // B: SH at 0x100 with addr_ok delayed three cycles; request fields must hold
    valid_in = 1; mem_write_flag_in = 1; mem_size_in = 2'b01;
    mem_addr_in = 32'h100; mem_write_data_in = 32'h1234; data_addr_ok = 0; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        tick();
        if (k == 1) begin mem_addr_in = 32'h998; mem_write_data_in = 32'hFFFF; end
        if (k == 3) data_addr_ok = 1;
        #1;
      end
      chk($sformatf("B_req_c%0d", k), data_req, 1);
      chk($sformatf("B_addr_c%0d", k), data_addr, 32'h100);
      chk($sformatf("B_wstrb_c%0d", k), data_wstrb, 4'b0011);
      chk($sformatf("B_wdata_c%0d", k), data_wdata, 32'h1234_1234);
    end
    tick();
    data_addr_ok = 0; #1;
    chk("B_wait_req", data_req, 0);
    chk("B_wait_stall", stall_request, 1);
    data_data_ok = 1; data_rdata = 32'h7777_7777;
    tick();
    data_data_ok = 0; idle_inputs(); #1;
    chk("B_rdata_kept", ram_read_data_out, 32'hDEAD_BEEF);
    chk("B_sel", mem_sel_out, 4'b0011);
    $display("seq B: SH sel=%b rdata=%h", mem_sel_out, ram_read_data_out);

    // C: flush in WAIT, late data_ok drained, then a new LW
    start_lw(32'h40, 1);
    tick();
    data_addr_ok = 0; flush = 1; #1;
    chk("C_flush_stall", stall_request, 1);
    tick();
    flush = 0; start_lw(32'h80, 0); #1;
    chk("C_drain1_req", data_req, 0);
    chk("C_drain1_stall", stall_request, 1);
    tick();
    data_data_ok = 1; data_rdata = 32'h1111_1111; #1;
    chk("C_drain2_req", data_req, 0);
    tick();
    data_data_ok = 0; data_addr_ok = 1; #1;
    chk("C_no_capture", ram_read_data_out, 32'hDEAD_BEEF);
    chk("C_new_req", data_req, 1);
    chk("C_new_addr", data_addr, 32'h80);
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h55AA_55AA;
    tick();
    data_data_ok = 0; idle_inputs(); #1;
    chk("C_rdata", ram_read_data_out, 32'h55AA_55AA);
    chk("C_sel", mem_sel_out, 4'b1111);
    $display("seq C: flush/drain rdata=%h", ram_read_data_out);

    // D: stall_next_stage held two cycles -> DONE holds data, ignores data_ok
    start_lw(32'h300, 1);
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0123_4567; stall_next_stage = 1;
    tick();
    data_rdata = 32'hBAD0_BAD0; #1;
    chk("D_done_rdata", ram_read_data_out, 32'h0123_4567);
    chk("D_done_sel", mem_sel_out, 4'b1111);
    chk("D_done_stall", stall_request, 0);
    chk("D_done_req", data_req, 0);
    tick();
    stall_next_stage = 0; data_data_ok = 0; #1;
    chk("D_done2_rdata", ram_read_data_out, 32'h0123_4567);
    chk("D_done2_req", data_req, 0);
    tick();
    idle_inputs(); #1;
    chk("D_idle_rdata", ram_read_data_out, 32'h0123_4567);
    $display("seq D: DONE hold rdata=%h", ram_read_data_out);

    // E: reset in WAIT abandons the access; late data_ok ignored
    start_lw(32'h400, 1);
    tick();
    data_addr_ok = 0; rst = 1; idle_inputs();
    tick();
    rst = 0; #1;
    chk("E_req", data_req, 0);
    chk("E_stall", stall_request, 0);
    chk("E_rdata", ram_read_data_out, 0);
    chk("E_sel", mem_sel_out, 0);
    chk("E_wstrb", data_wstrb, 0);
    data_data_ok = 1; data_rdata = 32'hFFFF_FFFF;
    tick();
    data_data_ok = 0; #1;
    chk("E_late_rdata", ram_read_data_out, 0);
    chk("E_late_sel", mem_sel_out, 0);
    chk("E_late_stall", stall_request, 0);
    $display("seq E: reset in WAIT rdata=%h", ram_read_data_out);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
